// File: rtl/cont_fwd.sv
// Forward-recursion controller for the MAP decoder: seeds alpha at BASE_ADDR, then
// runs N_STEPS read/add/compare/write trellis steps and pulses done_fwd at the end.
module cont_fwd #(
    parameter int unsigned N_STEPS   = 8,
    parameter int unsigned STRIDE    = 8,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       mem_gnt,
    output logic [7:0] fd_addr,
    output logic       w_r_a,
    output logic       init_en,
    output logic       add_en,
    output logic       cmp_en,
    output logic       busy,
    output logic [3:0] step_cnt,
    output logic       done_fwd
);

    // Out-of-range parameters wrap silently into the register widths.
    localparam logic [7:0] Stride   = 8'(STRIDE);
    localparam logic [7:0] BaseAddr = 8'(BASE_ADDR);
    localparam logic [3:0] NSteps   = 4'(N_STEPS);

    typedef enum logic [2:0] {
        StIdle,
        StInit,
        StRead,
        StAdd,
        StCmp,
        StWrite,
        StDone
    } state_e;

    state_e state_q;

    // Outputs are registered alongside the state so they track it cycle-exactly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            fd_addr  <= 8'd0;
            w_r_a    <= 1'b0;
            init_en  <= 1'b0;
            add_en   <= 1'b0;
            cmp_en   <= 1'b0;
            busy     <= 1'b0;
            step_cnt <= 4'd0;
            done_fwd <= 1'b0;
        end else begin
            init_en  <= 1'b0;
            add_en   <= 1'b0;
            cmp_en   <= 1'b0;
            done_fwd <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q  <= StInit;
                        step_cnt <= 4'd0;
                        fd_addr  <= BaseAddr;
                        w_r_a    <= 1'b1;
                        init_en  <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                StInit: begin
                    if (mem_gnt) begin
                        // READ reuses the seed address; no reload required.
                        state_q <= StRead;
                        w_r_a   <= 1'b0;
                    end else begin
                        init_en <= 1'b1;
                    end
                end
                StRead: begin
                    state_q <= StAdd;
                    add_en  <= 1'b1;
                end
                StAdd: begin
                    state_q <= StCmp;
                    cmp_en  <= 1'b1;
                end
                StCmp: begin
                    state_q <= StWrite;
                    w_r_a   <= 1'b1;
                    fd_addr <= fd_addr + Stride;
                end
                StWrite: begin
                    if (mem_gnt) begin
                        step_cnt <= step_cnt + 4'd1;
                        w_r_a    <= 1'b0;
                        if (step_cnt + 4'd1 == NSteps) begin
                            state_q  <= StDone;
                            done_fwd <= 1'b1;
                        end else begin
                            state_q <= StRead;
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                    w_r_a   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cont_fwd.sv
// Self-checking bench for cont_fwd: a per-cycle expected trace is expanded from the
// pass structure (init, N steps of read/add/cmp/write, done) and compared against the DUT.
module tb_cont_fwd;

    localparam int NS = 8;

    logic       clk = 1'b0;
    logic       rst, start, start2, mem_gnt;
    logic [7:0] fd_addr_a, fd_addr_b;
    logic       w_r_a_a, init_en_a, add_en_a, cmp_en_a, busy_a, done_fwd_a;
    logic       w_r_a_b, init_en_b, add_en_b, cmp_en_b, busy_b, done_fwd_b;
    logic [3:0] step_cnt_a, step_cnt_b;

    always #5 clk = ~clk;

    cont_fwd dut_a (
        .clk(clk), .rst(rst), .start(start), .mem_gnt(mem_gnt),
        .fd_addr(fd_addr_a), .w_r_a(w_r_a_a), .init_en(init_en_a), .add_en(add_en_a),
        .cmp_en(cmp_en_a), .busy(busy_a), .step_cnt(step_cnt_a), .done_fwd(done_fwd_a)
    );

    cont_fwd #(.N_STEPS(1), .STRIDE(16), .BASE_ADDR(240)) dut_b (
        .clk(clk), .rst(rst), .start(start2), .mem_gnt(mem_gnt),
        .fd_addr(fd_addr_b), .w_r_a(w_r_a_b), .init_en(init_en_b), .add_en(add_en_b),
        .cmp_en(cmp_en_b), .busy(busy_b), .step_cnt(step_cnt_b), .done_fwd(done_fwd_b)
    );

    typedef struct packed {
        logic [7:0] addr;
        logic       wra, init, add, cmp, busy, done;
        logic [3:0] cnt;
        logic       gnt;
    } ent_t;

    ent_t exp_q[$];
    ent_t obs_q[$];
    int   wstall[16];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic push(input int a, input logic wra, init, add, cmp, bsy, dn,
                        input int cnt, input logic gnt);
        ent_t e;
        e.addr = 8'(a); e.wra = wra; e.init = init; e.add = add; e.cmp = cmp;
        e.busy = bsy; e.done = dn; e.cnt = 4'(cnt); e.gnt = gnt;
        exp_q.push_back(e);
    endtask

    function automatic logic rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    // Expected per-cycle outputs, entry j = cycle after edge E0+j.
    task automatic build(input int n, input int s, input int b, input int init_stall,
                         input int tail);
        exp_q.delete();
        for (int i = 0; i <= init_stall; i++) push(b, 1, 1, 0, 0, 1, 0, 0, i == init_stall);
        for (int k = 0; k < n; k++) begin
            push(b + s * k, 0, 0, 0, 0, 1, 0, k, rnd_bit());
            push(b + s * k, 0, 0, 1, 0, 1, 0, k, rnd_bit());
            push(b + s * k, 0, 0, 0, 1, 1, 0, k, rnd_bit());
            for (int i = 0; i <= wstall[k]; i++)
                push(b + s * (k + 1), 1, 0, 0, 0, 1, 0, k, i == wstall[k]);
        end
        push(b + s * n, 0, 0, 0, 0, 1, 1, n, rnd_bit());
        for (int i = 0; i < tail; i++) push(b + s * n, 0, 0, 0, 0, 0, 0, n, rnd_bit());
    endtask

    function automatic ent_t sample(input bit which);
        ent_t e;
        if (which) begin
            e.addr = fd_addr_b; e.wra = w_r_a_b; e.init = init_en_b; e.add = add_en_b;
            e.cmp = cmp_en_b; e.busy = busy_b; e.done = done_fwd_b; e.cnt = step_cnt_b;
        end else begin
            e.addr = fd_addr_a; e.wra = w_r_a_a; e.init = init_en_a; e.add = add_en_a;
            e.cmp = cmp_en_a; e.busy = busy_a; e.done = done_fwd_a; e.cnt = step_cnt_a;
        end
        e.gnt = mem_gnt;
        return e;
    endfunction

    // Drives the trace's grant pattern and records outputs; entered #1 after an edge.
    task automatic play(input bit which, input bit do_start, input int start_at, input int len);
        int n;
        n = (len < 0) ? exp_q.size() : len;
        obs_q.delete();
        if (do_start) begin
            if (which) start2 = 1'b1; else start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0; start2 = 1'b0;
        end
        for (int i = 0; i < n; i++) begin
            mem_gnt = exp_q[i].gnt;
            if (which) start2 = (i == start_at); else start = (i == start_at);
            obs_q.push_back(sample(which));
            @(posedge clk); #1;
        end
        start = 1'b0; start2 = 1'b0;
    endtask

    task automatic test_reset();
        ent_t z;
        rst = 1'b1; start = 1'b0; start2 = 1'b0; mem_gnt = 1'b0;
        z = '0;
        #3;
        for (int w = 0; w < 2; w++) begin
            n_vec++;
            if (sample(w[0]) !== z) begin
                n_bad++;
                $display("FAIL reset dut%0d: got %h want %h", w, sample(w[0]), z);
            end
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_nominal();
        int first, cnt;
        foreach (wstall[k]) wstall[k] = 0;
        build(NS, 8, 0, 0, 3);
        play(0, 1, 1 + 4 * NS, -1);  // start during DONE must be ignored
        for (int i = 0; i < obs_q.size(); i++) begin
            n_vec++;
            if (obs_q[i] !== exp_q[i]) begin
                n_bad++;
                $display("FAIL nominal cyc %0d: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        first = -1; cnt = 0;
        for (int i = 0; i < obs_q.size(); i++)
            if (obs_q[i].done) begin cnt++; if (first < 0) first = i; end
        n_vec++;
        if (cnt !== 1 || first !== 33) begin
            n_bad++;
            $display("FAIL nominal_done: got %0d pulses at %0d want 1 at 33", cnt, first);
        end
    endtask

    task automatic test_stall();
        int first;
        foreach (wstall[k]) wstall[k] = 0;
        wstall[2] = 3;
        build(NS, 8, 0, 0, 1);
        play(0, 1, -1, -1);
        for (int i = 0; i < obs_q.size(); i++) begin
            n_vec++;
            if (obs_q[i] !== exp_q[i]) begin
                n_bad++;
                $display("FAIL stall cyc %0d: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        first = -1;
        for (int i = 0; i < obs_q.size(); i++) if (obs_q[i].done && first < 0) first = i;
        n_vec++;
        if (first !== 36) begin
            n_bad++;
            $display("FAIL stall_done_pos: got %0d want 36", first);
        end
    endtask

    task automatic test_ignored_start();
        foreach (wstall[k]) wstall[k] = 0;
        build(NS, 8, 0, 0, 2);
        play(0, 1, 1 + 4 * 4 + 1, -1);  // ADD of step 4
        for (int i = 0; i < obs_q.size(); i++) begin
            n_vec++;
            if (obs_q[i] !== exp_q[i]) begin
                n_bad++;
                $display("FAIL busy_start cyc %0d: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        ent_t z;
        foreach (wstall[k]) wstall[k] = 0;
        build(NS, 8, 0, 0, 1);
        play(0, 1, -1, 1 + 4 * 5 + 2);  // stop as CMP of step 5 begins
        for (int i = 0; i < obs_q.size(); i++) begin
            n_vec++;
            if (obs_q[i] !== exp_q[i]) begin
                n_bad++;
                $display("FAIL pre_rst cyc %0d: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        mem_gnt = 1'b0;
        #2 rst = 1'b1;
        #1;
        z = '0;
        n_vec++;
        if (sample(0) !== z) begin
            n_bad++;
            $display("FAIL async_rst: got %h want %h", sample(0), z);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            mem_gnt = rnd_bit();
            @(posedge clk); #1;
            n_vec++;
            if (done_fwd_a !== 1'b0 || busy_a !== 1'b0) begin
                n_bad++;
                $display("FAIL post_rst cyc %0d: got done=%b busy=%b want 0 0", i,
                         done_fwd_a, busy_a);
            end
        end
        build(NS, 8, 0, 0, 1);
        play(0, 1, -1, -1);
        for (int i = 0; i < obs_q.size(); i++) begin
            n_vec++;
            if (obs_q[i] !== exp_q[i]) begin
                n_bad++;
                $display("FAIL after_rst cyc %0d: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_random_stalls();
        for (int it = 0; it < 3; it++) begin
            foreach (wstall[k]) wstall[k] = (k < NS) ? int'($urandom_range(0, 3)) : 0;
            build(NS, 8, 0, int'($urandom_range(0, 2)), 1);
            play(0, 1, -1, -1);
            for (int i = 0; i < obs_q.size(); i++) begin
                n_vec++;
                if (obs_q[i] !== exp_q[i]) begin
                    n_bad++;
                    $display("FAIL rand%0d cyc %0d: got %h want %h", it, i, obs_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        foreach (wstall[k]) wstall[k] = 0;
        build(NS, 8, 0, 0, 1);
        play(0, 1, 2 + 4 * NS, -1);  // start in the first IDLE cycle
        for (int i = 0; i < obs_q.size(); i++) begin
            n_vec++;
            if (obs_q[i] !== exp_q[i]) begin
                n_bad++;
                $display("FAIL b2b_first cyc %0d: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        wstall[5] = 1;
        build(NS, 8, 0, 1, 1);
        play(0, 0, -1, -1);
        for (int i = 0; i < obs_q.size(); i++) begin
            n_vec++;
            if (obs_q[i] !== exp_q[i]) begin
                n_bad++;
                $display("FAIL b2b_second cyc %0d: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_small_wrap();
        foreach (wstall[k]) wstall[k] = 0;
        build(1, 16, 240, 0, 2);
        play(1, 1, -1, -1);
        for (int i = 0; i < obs_q.size(); i++) begin
            n_vec++;
            if (obs_q[i] !== exp_q[i]) begin
                n_bad++;
                $display("FAIL wrap cyc %0d: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_stall();
        test_ignored_start();
        test_reset_mid();
        test_random_stalls();
        test_back_to_back();
        test_small_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
